// File: rtl/mux8_rr_merge.sv
`default_nettype none
// ============================================================================
// Module   : mux8_rr_merge
// Purpose  : 8:1 round-robin merge of valid/ready channels onto one
//            registered output stream tagged with the source channel index.
// Revision : 1.0
// ============================================================================
module mux8_rr_merge #(
  parameter int DW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [8*DW-1:0] in_data,
  input  logic [7:0]      in_valid,
  output logic [7:0]      in_ready,
  output logic [DW-1:0]   out_data,
  output logic [2:0]      out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [2:0]    r_ptr;
  logic [DW-1:0] r_data;
  logic [2:0]    r_sel;
  logic          r_valid;

  logic          w_load;
  logic          w_found;
  logic [2:0]    w_win;
  logic [2:0]    w_idx;
  logic [DW-1:0] w_chan [8];

  for (genvar k = 0; k < 8; k++) begin : g_chan
    assign w_chan[k] = in_data[k*DW +: DW];
  end

  // Register is free when empty or when its current beat drains this cycle.
  assign w_load = ~r_valid | out_ready;

  // Search starts at ptr and wraps; the first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    w_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_idx = r_ptr + 3'(i);
      if (!w_found && in_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Gated by rst_n so no channel sees an accept while held in reset.
  assign in_ready = (rst_n && w_load && w_found) ? (8'h01 << w_win) : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= 3'd0;
      r_data  <= '0;
      r_sel   <= 3'd0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      if (w_found) begin
        r_data  <= w_chan[w_win];
        r_sel   <= w_win;
        r_valid <= 1'b1;
        r_ptr   <= w_win + 3'd1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux8_rr_merge
// Purpose  : Directed and loopback checks of the 8:1 round-robin merge.
// Revision : 1.0
// ============================================================================
module tb_mux8_rr_merge;

  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic [8*DW-1:0] in_data;
  logic [7:0]      in_valid;
  logic [7:0]      in_ready;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_sel;
  logic            out_valid;
  logic            out_ready;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q [0:7][$];
  logic [7:0]    cur_valid;
  logic [DW-1:0] cur_data [0:7];

  mux8_rr_merge #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    in_data[k*DW +: DW] = v;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    #12;
    // Reset state, with requests present to prove in_ready is gated.
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sel",   64'(out_sel),   64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_ready", 64'(in_ready),  64'h00);

    in_valid = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_valid", 64'(out_valid), 64'd0);

    // Single channel 5.
    in_valid = 8'b0010_0000;
    set_ch(5, 8'hA5);
    #1;
    check("single_ready", 64'(in_ready), 64'h20);
    tick();
    in_valid = 8'h00;
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_sel",   64'(out_sel),   64'd5);
    check("single_data",  64'(out_data),  64'hA5);
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_hold_sel", 64'(out_sel), 64'd5);

    // Wrap and skip: ptr is 6 here.
    in_valid = 8'b0000_0101;
    set_ch(0, 8'h10);
    set_ch(2, 8'h12);
    #1;
    check("wrap_ready0", 64'(in_ready), 64'h01);
    tick();
    check("wrap_sel0",  64'(out_sel),  64'd0);
    check("wrap_data0", 64'(out_data), 64'h10);
    in_valid = 8'b0000_0100;
    #1;
    check("wrap_ready2", 64'(in_ready), 64'h04);
    tick();
    check("wrap_sel2",  64'(out_sel),  64'd2);
    check("wrap_data2", 64'(out_data), 64'h12);
    in_valid = 8'h80;
    set_ch(7, 8'h77);
    #1;
    check("ch7_ready", 64'(in_ready), 64'h80);
    tick();
    check("ch7_sel",  64'(out_sel),  64'd7);
    check("ch7_data", 64'(out_data), 64'h77);
    in_valid = 8'h00;
    tick();
    check("ch7_idle", 64'(out_valid), 64'd0);

    // Full contention from ptr 0.
    for (int k = 0; k < 8; k++) set_ch(k, 8'(8'h30 + k));
    in_valid = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_valid", 64'(out_valid), 64'd1);
      check("rr_sel",   64'(out_sel),   64'(i % 8));
      check("rr_data",  64'(out_data),  64'(8'h30 + (i % 8)));
    end

    // Advance to sel 3, then stall.
    tick();
    tick();
    tick();
    check("bp_pre_sel", 64'(out_sel), 64'd3);
    out_ready = 1'b0;
    #1;
    check("bp_ready", 64'(in_ready), 64'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_sel",   64'(out_sel),   64'd3);
      check("bp_data",  64'(out_data),  64'h33);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_ready_hold", 64'(in_ready), 64'h00);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'h10);
    tick();
    check("bp_next_sel",  64'(out_sel),  64'd4);
    check("bp_next_data", 64'(out_data), 64'h34);

    // Asynchronous reset mid-stream (ptr would be 5 otherwise).
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sel",   64'(out_sel),   64'd0);
    check("mid_rst_data",  64'(out_data),  64'd0);
    check("mid_rst_ready", 64'(in_ready),  64'h00);
    in_valid = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    in_valid = 8'h41;
    #1;
    check("post_rst_ptr", 64'(in_ready), 64'h01);
    tick();
    check("post_rst_sel", 64'(out_sel), 64'd0);
    in_valid = 8'h00;
    tick();

    // Random loopback through a modelled 1:8 demux.
    cur_valid = 8'h00;
    for (int k = 0; k < 8; k++) cur_data[k] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = (cyc < 360) ? cur_valid : 8'h00;
      for (int k = 0; k < 8; k++) set_ch(k, cur_data[k]);
      out_ready = (cyc < 360) ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        if (q[out_sel].size() == 0) begin
          check("lb_dup", 64'(out_sel), 64'hFF);
        end else begin
          check("lb_data", 64'(out_data), 64'(q[out_sel].pop_front()));
        end
      end
      check("lb_onehot", 64'($countones(in_ready) <= 1), 64'd1);
      check("lb_subset", 64'(in_ready & ~in_valid), 64'h00);
      for (int k = 0; k < 8; k++) begin
        if (in_valid[k] && in_ready[k]) begin
          q[k].push_back(cur_data[k]);
          cur_valid[k] = 1'($urandom_range(0, 1));
          cur_data[k]  = 8'($urandom_range(0, 255));
        end else if (!cur_valid[k]) begin
          cur_valid[k] = 1'($urandom_range(0, 2) == 0);
          cur_data[k]  = 8'($urandom_range(0, 255));
        end
      end
      tick();
    end
    for (int k = 0; k < 8; k++) check("lb_loss", 64'(q[k].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux8_rr_merge.md
Name: mux8_rr_merge

Overview:
- Sequential 8:1 merge block; the gathering counterpart to the 1:8 demultiplexer.
- Takes 8 independent valid/ready input channels and arbitrates between them round-robin.
- Forwards one beat per cycle onto a single registered output stream.
- The output carries a 3-bit channel tag (out_sel), so a downstream 1:8 demux can route each beat back by s = out_sel.

Parameters:
- DW, 1, data width of each channel and of the output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_data  input  8*DW  channel k data at bits [k*DW +: DW].
- in_valid  input  8  channel k has a beat pending.
- in_ready  output  8  channel k beat accepted this cycle when in_valid[k] & in_ready[k].
- out_data  output  DW  registered data of the granted channel.
- out_sel  output  3  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_sel hold a beat.
- out_ready  input  1  downstream accepts; transfer on out_valid & out_ready.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values (asserted immediately, independent of clk):
  - out_valid = 0, out_data = 0, out_sel = 3'b000.
  - Round-robin pointer ptr = 3'd0.
  - in_ready = 8'h00 while rst_n = 0.
- Output register:
  - load_en = ~out_valid | out_ready (register empty or draining this cycle).
  - Pure combinational function of current state and inputs; no skid buffer.
- Arbitration (combinational, each cycle):
  - Search channels ptr, ptr+1, …, ptr+7, mod 8.
  - First k with in_valid[k] = 1 is the winner.
  - No in_valid set -> no winner.
- in_ready:
  - in_ready[k] = load_en & (k == winner).
  - At most one in_ready bit is high in any cycle.
  - in_ready is all-zero when there is no winner or load_en = 0.
- On the clk edge with load_en = 1 and a winner w:
  - out_data <= in_data[w*DW +: DW], out_sel <= w, out_valid <= 1.
  - ptr <= w+1, wrapping 7 -> 0.
- On the clk edge with load_en = 1 and no winner:
  - out_valid <= 0; out_data/out_sel hold their last values; ptr unchanged.
- On the clk edge with load_en = 0 (out_valid = 1, out_ready = 0):
  - Output stalls: out_data, out_sel, out_valid, ptr all hold.
  - No input is accepted.
- Latency and throughput:
  - 1 cycle from input acceptance to out_valid.
  - Sustained 1 beat/cycle when out_ready is held high.
- Fairness:
  - A channel that holds in_valid waits at most 7 accepted beats from other channels before it is granted.
  - All 8 requesting -> grants cycle 0,1,…,7,0,…
- Input rules:
  - Inputs must hold in_valid/in_data stable until accepted; the block does not check this.
  - Deasserting in_valid before acceptance is legal; that channel simply loses eligibility.
- Simultaneous events:
  - Drain and load in the same cycle (out_valid = 1, out_ready = 1, winner present): the new beat replaces the old one, with no bubble.
  - out_ready = 1 while out_valid = 0: no effect beyond load_en = 1.
- Reset mid-operation:
  - Any in-flight output beat is discarded; out_valid drops to 0 asynchronously.
  - ptr returns to 0; first grant after reset release starts search at channel 0.
- Combinational paths:
  - No path from in_data to out_data; output is fully registered.
  - in_ready depends combinationally on in_valid, out_ready, out_valid and ptr.

Test Plan:
- Reset/idle: assert rst_n = 0 mid-stream with out_valid = 1 -> out_valid = 0, out_sel = 0, out_data = 0, in_ready = 0 before the next clk edge. Release reset with all in_valid = 0 -> out_valid stays 0.
- Single channel (DW = 1): in_valid = 8'b0010_0000, in_data bit5 = 1, out_ready = 1 -> in_ready = 8'b0010_0000 that cycle. Next cycle: out_valid = 1, out_sel = 5, out_data = 1.
- Full contention: in_valid = 8'hFF held, out_ready = 1 -> out_sel sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles, with no gaps.
- Backpressure: output holding sel = 3, out_ready = 0 for 4 cycles while in_valid = 8'hFF -> in_ready = 0, out_data/out_sel stable. On out_ready = 1, the next beat is from sel = 4.
- Wrap and skip: ptr = 6, in_valid = 8'b0000_0101 -> winner 0, then 2. A later request on 7 alone -> winner 7, then ptr = 0.
- Demux loopback: feed out_data/out_sel into a 1:8 demux (din = out_data, s = out_sel) gated by out_valid, with random in_valid/in_data on 8 channels -> per-channel data sequences are reproduced in order, with no loss or duplication.
